// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between the FIFO and its producer/consumer.
// The slave modport is the FIFO side; the master modport is the client side.
interface sync_fifo_param_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with fill level, threshold flags and handshake pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave f
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic                  wr_ack_q, overflow_q, underflow_q;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_acc = f.rd_en && !empty;
  assign wr_acc = f.wr_en && (!full || f.rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= f.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_acc;
      overflow_q  <= f.wr_en && !wr_acc;
      underflow_q <= f.rd_en && !rd_acc;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always presented; rd_en only pops it.
  assign f.data_out = mem[rd_ptr];
  assign f.rd_valid = !empty;
`else
  logic [FIFO_WIDTH-1:0] data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) data_q <= mem[rd_ptr];
    end
  end

  assign f.data_out = data_q;
  assign f.rd_valid = rd_valid_q;
`endif

  assign f.wr_ack      = wr_ack_q;
  assign f.overflow    = overflow_q;
  assign f.underflow   = underflow_q;
  assign f.full        = full;
  assign f.empty       = empty;
  assign f.almostfull  = (count >= CW'(AF_THRESH));
  assign f.almostempty = (count <= CW'(AE_THRESH));
  assign f.count       = count;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH 16, WIDTH 8); read checks adapt to SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic       m_wr, m_rd, m_racc, m_wacc;

  sync_fifo_param_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(16)) bus ();

  sync_fifo_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk (clk),
    .rst (rst),
    .f   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and leave the bench 1 time unit after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [7:0] din);
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  // Pop one word and check it in whichever read mode is built.
  task automatic pop(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    #1;
    chk({tag, "_data"}, 32'(bus.data_out), 32'(exp));
    chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
    cyc(1'b0, 1'b1, 8'h00);
`else
    cyc(1'b0, 1'b1, 8'h00);
    chk({tag, "_data"}, 32'(bus.data_out), 32'(exp));
    chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
`endif
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ae", 32'(bus.almostempty), 32'd1);
    chk("rst_af", 32'(bus.almostfull), 32'd0);
    chk("rst_pulses", {29'd0, bus.wr_ack, bus.overflow, bus.underflow}, 32'd0);
    chk("rst_vld", 32'(bus.rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout", 32'(bus.data_out), 32'd0);
`endif
    rst = 1'b0;

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      chk("fill_ack", 32'(bus.wr_ack), 32'd1);
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_af", 32'(bus.almostfull), 32'(i >= 14));
      chk("fill_ae", 32'(bus.almostempty), 32'(i <= 2));
      chk("fill_full", 32'(bus.full), 32'(i == 16));
    end
    cyc(1'b1, 1'b0, 8'h99);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_ack", 32'(bus.wr_ack), 32'd0);
    chk("ovf_count", 32'(bus.count), 32'd16);
    cyc(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(bus.overflow), 32'd0);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      pop("drain", 8'(i));
      chk("drain_count", 32'(bus.count), 32'(16 - i));
    end
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_flag", 32'(bus.underflow), 32'd1);
    chk("udf_empty", 32'(bus.empty), 32'd1);
    chk("udf_vld", 32'(bus.rd_valid), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);
    chk("udf_clear", 32'(bus.underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("dout_hold", 32'(bus.data_out), 32'h10);
`endif

    // Simultaneous read/write while full
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
    chk("refill_full", 32'(bus.full), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fullrw_head", 32'(bus.data_out), 32'h01);
`endif
    cyc(1'b1, 1'b1, 8'hAA);
    chk("fullrw_count", 32'(bus.count), 32'd16);
    chk("fullrw_ovf", 32'(bus.overflow), 32'd0);
    chk("fullrw_ack", 32'(bus.wr_ack), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("fullrw_data", 32'(bus.data_out), 32'h01);
`endif
    for (int i = 2; i <= 16; i++) pop("fullrw_drain", 8'(i));
    pop("fullrw_tail", 8'hAA);
    chk("fullrw_empty", 32'(bus.empty), 32'd1);

    // Simultaneous read/write while empty
    cyc(1'b1, 1'b1, 8'h55);
    chk("emptyrw_count", 32'(bus.count), 32'd1);
    chk("emptyrw_udf", 32'(bus.underflow), 32'd1);
    chk("emptyrw_ack", 32'(bus.wr_ack), 32'd1);
    pop("emptyrw_read", 8'h55);
    chk("emptyrw_after", 32'(bus.count), 32'd0);

    // Interleaved traffic against a queue model; pointers have already wrapped several times
    q = {};
    for (int k = 0; k < 40; k++) begin
      m_wr   = (((k / 6) % 2) == 0) || ((k % 3) == 0);
      m_rd   = (((k / 6) % 2) == 1) || ((k % 4) == 0);
      m_racc = m_rd && (q.size() > 0);
      m_wacc = m_wr && ((q.size() < 16) || m_rd);
      exp_d  = m_racc ? q[0] : 8'h00;
`ifdef SYNC_FIFO_FWFT_EN
      bus.wr_en = m_wr; bus.rd_en = m_rd; bus.data_in = 8'(8'h80 + k);
      #1;
      if (m_racc) chk("wrap_data", 32'(bus.data_out), 32'(exp_d));
`endif
      cyc(m_wr, m_rd, 8'(8'h80 + k));
      if (m_racc) void'(q.pop_front());
      if (m_wacc) q.push_back(8'(8'h80 + k));
      chk("wrap_count", 32'(bus.count), 32'(q.size()));
`ifndef SYNC_FIFO_FWFT_EN
      chk("wrap_vld", 32'(bus.rd_valid), 32'(m_racc));
      if (m_racc) chk("wrap_data", 32'(bus.data_out), 32'(exp_d));
`endif
    end
    while (q.size() > 0) pop("wrap_flush", q.pop_front());
    chk("wrap_empty", 32'(bus.empty), 32'd1);

`ifdef SYNC_FIFO_FWFT_EN
    cyc(1'b1, 1'b0, 8'h3C);
    cyc(1'b0, 1'b0, 8'h00);
    chk("fwft_data", 32'(bus.data_out), 32'h3C);
    chk("fwft_vld", 32'(bus.rd_valid), 32'd1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("fwft_empty", 32'(bus.empty), 32'd1);
    chk("fwft_vld0", 32'(bus.rd_valid), 32'd0);
`endif

    // Reset in the middle of a write burst
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 8'h33);
    #1 rst = 1'b1;
    #1;
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_pulses", {28'd0, bus.wr_ack, bus.overflow, bus.underflow, bus.rd_valid}, 32'd0);
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 1'b1, 8'h00);
    chk("postrst_udf", 32'(bus.underflow), 32'd1);
    chk("postrst_count", 32'(bus.count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
